// File: rtl/encode_mul_arb_pkg.sv
// rtl/encode_mul_arb_pkg.sv - shared widths, id width helper and response tag type for encode_mul_arbiter
package encode_mul_arb_pkg;

    localparam int A_W_DEF  = 40;
    localparam int B_W_DEF  = 27;
    localparam int P_W_DEF  = 66;

    // Widest requester index supported (NUM_REQ up to 8).
    localparam int ID_MAX_W = 3;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One entry of the tag pipe that travels alongside the multiplier.
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } rsp_tag_t;

endpackage

// File: rtl/encode_rr_arbiter.sv
// rtl/encode_rr_arbiter.sv - round-robin one-hot arbiter with pointer advancing past each accepted requester
module encode_rr_arbiter
    import encode_mul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] r_ptr;
    int              w_j;

    // Pick the first requesting index at or after the pointer, wrapping cyclically.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = (int'(r_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = ID_W'(w_j);
            end
        end
    end

    // Move the pointer just past the winner, only when the grant is actually taken.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_en && o_any) begin
            r_ptr <= (o_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/encode_mul_arbiter.sv
// rtl/encode_mul_arbiter.sv - shares one pipelined multiplier among requesters; optional ENCODE_MUL_ARB_PERF_EN counters
module encode_mul_arbiter
    import encode_mul_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int A_W     = A_W_DEF,
    parameter  int B_W     = B_W_DEF,
    parameter  int P_W     = P_W_DEF,
    parameter  int MUL_LAT = 1,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_data
`ifdef ENCODE_MUL_ARB_PERF_EN
    ,
    output logic [31:0]            perf_busy,
    output logic [31:0]            perf_stall
`endif
);

    logic               w_advance;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    rsp_tag_t           w_tag_in;
    rsp_tag_t           r_tag [MUL_LAT];
    logic               w_unused_id;

    // The whole pipe moves only when the output slot is empty or being drained.
    assign w_advance = !rsp_valid || rsp_ready;
    assign mul_ce    = w_advance;

    // No request may win while reset is held, so nothing is accepted in that cycle.
    assign w_req     = req_valid & ~{NUM_REQ{reset}};

    encode_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_req   (w_req),
        .i_en    (w_advance),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept  = w_any && w_advance;
    assign req_ready = w_grant & {NUM_REQ{w_advance}};

    // Steer the granted operand pair to the multiplier; zeros when idle.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    // Stage-0 tag: accept flag plus winner id (bubbles carry valid=0).
    always_comb begin
        w_tag_in             = '0;
        w_tag_in.valid       = w_accept;
        w_tag_in.id[ID_W-1:0] = w_idx;
    end

    // Tag shift register tracking the multiplier's stages, frozen together with mul_ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else if (w_advance) begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign rsp_valid   = r_tag[MUL_LAT-1].valid;
    assign rsp_id      = r_tag[MUL_LAT-1].id[ID_W-1:0];
    assign rsp_data    = mul_dout;
    assign w_unused_id = ^r_tag[MUL_LAT-1].id;

`ifdef ENCODE_MUL_ARB_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    // Saturating activity counters: accepted issues and stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept && (r_perf_busy != 32'hFFFF_FFFF)) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if (!w_advance && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_busy  = r_perf_busy;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_encode_mul_arbiter.sv
// tb/tb_encode_mul_arbiter.sv - self-checking bench for encode_mul_arbiter with a one-stage multiplier model
module tb_encode_mul_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [159:0] req_a = '0;
    logic [107:0] req_b = '0;
    logic         mul_ce;
    logic [39:0]  mul_din0;
    logic [26:0]  mul_din1;
    logic [65:0]  mul_dout = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [65:0]  rsp_data;
`ifdef ENCODE_MUL_ARB_PERF_EN
    logic [31:0]  perf_busy;
    logic [31:0]  perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  id;
        logic [65:0] p;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;

    encode_mul_arbiter #(
        .NUM_REQ (4),
        .A_W     (40),
        .B_W     (27),
        .P_W     (66),
        .MUL_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef ENCODE_MUL_ARB_PERF_EN
        ,
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Signed x unsigned product truncated to the 66-bit dout width.
    function automatic logic [65:0] prod(input logic [39:0] a, input logic [26:0] b);
        logic signed [66:0] f;
        f = $signed(a) * $signed({1'b0, b});
        return f[65:0];
    endfunction

    // Single-register multiplier with clock enable.
    always @(posedge clk) begin
        if (mul_ce) mul_dout <= prod(mul_din0, mul_din1);
    end

    function automatic logic [159:0] rand_a();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [107:0] rand_b();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[107:0];
    endfunction

    // One cycle: drive, check against the model, then advance the model past the coming edge.
    task automatic step(input logic [3:0] v, input logic rr, input logic [159:0] a, input logic [107:0] b);
        int          g;
        logic        adv;
        logic [3:0]  eg;
        logic [39:0] ed0;
        logic [26:0] ed1;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        req_a     = a;
        req_b     = b;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (g < 0 && v[j]) g = j;
        end
        adv = (q.size() == 0) || rr;
        eg  = (g >= 0 && adv) ? 4'(1 << g) : 4'b0;
        ed0 = (g >= 0) ? a[g*40 +: 40] : 40'd0;
        ed1 = (g >= 0) ? b[g*27 +: 27] : 27'd0;
        checks++;
        if (req_ready !== eg) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b", req_ready, eg);
        end
        checks++;
        if (mul_ce !== adv) begin
            errors++;
            $display("FAIL mul_ce: got %b expected %b", mul_ce, adv);
        end
        checks++;
        if ({mul_din0, mul_din1} !== {ed0, ed1}) begin
            errors++;
            $display("FAIL mul_din: got %h/%h expected %h/%h", mul_din0, mul_din1, ed0, ed1);
        end
        checks++;
        if (rsp_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, q.size() != 0);
        end
        if (q.size() != 0) begin
            checks++;
            if ({rsp_id, rsp_data} !== {q[0].id, q[0].p}) begin
                errors++;
                $display("FAIL rsp_payload: got id=%0d data=%h expected id=%0d data=%h",
                         rsp_id, rsp_data, q[0].id, q[0].p);
            end
        end
        if (q.size() != 0 && rr) void'(q.pop_front());
        if (g >= 0 && adv) begin
            q.push_back('{id: 2'(g), p: prod(a[g*40 +: 40], b[g*27 +: 27])});
            m_ptr = (g + 1) % 4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_ready_during: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id} !== 3'b0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b id=%0d expected 0/0", rsp_valid, rsp_id);
        end
        checks++;
        if (mul_ce !== 1'b1 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_ce_ready: got ce=%b ready=%b expected 1/0000", mul_ce, req_ready);
        end
        reset     = 1'b0;
        req_valid = 4'b0;
        q.delete();
        m_ptr = 0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        logic [159:0] a;
        logic [107:0] b;
        logic [65:0]  e;
        do_reset();
        a = rand_a();
        b = rand_b();
        a[39:0] = -40'sd3;
        b[26:0] = 27'd5;
        step(4'b0001, 1'b1, a, b);
        step(4'b0000, 1'b1, rand_a(), rand_b());
        e = -66'sd15;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, e}) begin
            errors++;
            $display("FAIL single: got v=%b id=%0d data=%h expected 1/0/%h", rsp_valid, rsp_id, rsp_data, e);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'hF, 1'b1, rand_a(), rand_b());
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL rr_grant: got %b expected %b", req_ready, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin
                    errors++;
                    $display("FAIL rr_id: got v=%b id=%0d expected 1/%0d", rsp_valid, rsp_id, (k - 1) % 4);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            step(4'hF, 1'b0, rand_a(), rand_b());
            checks++;
            if ({mul_ce, req_ready, rsp_valid, rsp_id} !== {1'b0, 4'b0, 1'b1, 2'd3}) begin
                errors++;
                $display("FAIL stall: got ce=%b ready=%b v=%b id=%0d expected 0/0000/1/3",
                         mul_ce, req_ready, rsp_valid, rsp_id);
            end
        end
        step(4'hF, 1'b1, rand_a(), rand_b());
        checks++;
        if (rsp_id !== 2'd3 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL stall_resume: got id=%0d ready=%b expected 3/0001", rsp_id, req_ready);
        end
        step(4'h0, 1'b1, rand_a(), rand_b());
        step(4'h0, 1'b1, rand_a(), rand_b());
    endtask

    task automatic test_extremes();
        logic [159:0] a;
        logic [107:0] b;
        logic [65:0]  e;
        logic signed [66:0] f;
        do_reset();
        a = '0;
        b = '0;
        a[39:0] = 40'h80_0000_0000;
        b[26:0] = 27'h7FF_FFFF;
        step(4'b0001, 1'b1, a, b);
        a[39:0] = 40'h7F_FFFF_FFFF;
        b[26:0] = 27'd0;
        step(4'b0001, 1'b1, a, b);
        f = -(67'sd1 <<< 39) * 67'sd134217727;
        e = f[65:0];
        checks++;
        if (rsp_data !== e) begin
            errors++;
            $display("FAIL extreme_min: got %h expected %h", rsp_data, e);
        end
        step(4'b0000, 1'b1, a, b);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 66'd0) begin
            errors++;
            $display("FAIL extreme_zero: got v=%b data=%h expected 1/0", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_pointer();
        do_reset();
        step(4'b0100, 1'b1, rand_a(), rand_b());
        step(4'b1010, 1'b1, rand_a(), rand_b());
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL ptr_first: got %b expected 1000", req_ready);
        end
        step(4'b1010, 1'b1, rand_a(), rand_b());
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL ptr_second: got %b expected 0010", req_ready);
        end
        step(4'b0000, 1'b1, rand_a(), rand_b());
    endtask

    task automatic test_single_hold();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b0100, 1'b1, rand_a(), rand_b());
            checks++;
            if (req_ready !== 4'b0100) begin
                errors++;
                $display("FAIL hold_grant: got %b expected 0100", req_ready);
            end
        end
        step(4'b0000, 1'b1, rand_a(), rand_b());
    endtask

    task automatic test_reset_mid();
        step(4'b0100, 1'b1, rand_a(), rand_b());
        do_reset();
        step(4'hF, 1'b1, rand_a(), rand_b());
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b v=%b expected 0001/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0), rand_a(), rand_b());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_extremes();
        test_pointer();
        test_single_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
